// File: rtl/instr_fetch_param.sv
// Parametrised MIPS instruction-fetch stage: loader-filled instruction memory, PC and IDLE/RUN/HALTED control.
// Define IF_JUMP_FLUSH_EN to replace the delay-slot word with a bubble on a jump.
module instr_fetch_param #(
  parameter int                 NB_DATA     = 32,
  parameter int                 MEM_DEPTH   = 64,
  parameter logic [NB_DATA-1:0] PC_RESET    = '0,
  parameter logic [NB_DATA-1:0] HALT_OPCODE = {NB_DATA{1'b1}}
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_we,
  input  logic [NB_DATA-1:0] i_instr_data,
  input  logic               i_start,
  input  logic               i_jump,
  input  logic [NB_DATA-1:0] i_addr2jump,
  input  logic               i_stall,
  input  logic               i_halt,
  output logic [NB_DATA-1:0] o_pcounter,
  output logic [NB_DATA-1:0] o_pcounter4,
  output logic [NB_DATA-1:0] o_instruction,
  output logic               o_valid,
  output logic               o_halted,
  output logic               o_mem_full
);

  localparam int                 AW         = $clog2(MEM_DEPTH);
  localparam logic [AW:0]        DEPTH_CNT  = (AW+1)'(MEM_DEPTH);
  localparam logic [AW:0]        PTR_ONE    = (AW+1)'(1);
  localparam logic [NB_DATA:0]   MEM_BYTES  = (NB_DATA+1)'(4*MEM_DEPTH);
  localparam logic [NB_DATA-1:0] PC_STEP    = NB_DATA'(4);
  localparam logic [NB_DATA-1:0] ALIGN_MASK = ~(NB_DATA'(3));

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] pc_q, pc_d;
  logic [NB_DATA-1:0] pcounter_q, pcounter_d;
  logic [NB_DATA-1:0] pcounter4_q, pcounter4_d;
  logic [NB_DATA-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;
  logic               mem_full_q, mem_full_d;
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [NB_DATA-1:0] mem_q [MEM_DEPTH];
  logic [NB_DATA-1:0] mem_d [MEM_DEPTH];
  logic [NB_DATA-1:0] fetch_word_s;
  logic               halt_seen_s;

  // Addresses past the end of memory fetch a NOP rather than aliasing.
  always_comb begin
    if ({1'b0, pc_q} < MEM_BYTES) begin
      fetch_word_s = mem_q[pc_q[AW+1:2]];
    end else begin
      fetch_word_s = '0;
    end
  end

  // The halt word is issued for one cycle before the stage stops.
  assign halt_seen_s = valid_q && (instr_q == HALT_OPCODE);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pcounter_d  = pcounter_q;
    pcounter4_d = pcounter4_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    wr_ptr_d    = wr_ptr_q;
    mem_d       = mem_q;
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (i_we && (wr_ptr_q != DEPTH_CNT)) begin
          mem_d[wr_ptr_q[AW-1:0]] = i_instr_data;
          wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
        if (i_start) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (i_halt || halt_seen_s) begin
          state_d = S_HALTED;
          valid_d = 1'b0;
        end else if (i_stall) begin
          state_d = S_RUN;
        end else if (i_jump) begin
          pc_d = i_addr2jump & ALIGN_MASK;
`ifdef IF_JUMP_FLUSH_EN
          instr_d = '0;
          valid_d = 1'b0;
`else
          instr_d     = fetch_word_s;
          pcounter_d  = pc_q;
          pcounter4_d = pc_q + PC_STEP;
          valid_d     = 1'b1;
`endif
        end else begin
          instr_d     = fetch_word_s;
          pcounter_d  = pc_q;
          pcounter4_d = pc_q + PC_STEP;
          valid_d     = 1'b1;
          pc_d        = pc_q + PC_STEP;
        end
      end
      S_HALTED: begin
        valid_d = 1'b0;
        if (i_start) begin
          state_d = S_RUN;
        end else begin
          state_d = S_HALTED;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
    halted_d   = (state_d == S_HALTED);
    mem_full_d = (wr_ptr_d == DEPTH_CNT);
  end

  // State, PC, output and memory registers; reset clears everything including memory.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      pc_q        <= PC_RESET;
      pcounter_q  <= '0;
      pcounter4_q <= '0;
      instr_q     <= '0;
      valid_q     <= 1'b0;
      halted_q    <= 1'b0;
      mem_full_q  <= 1'b0;
      wr_ptr_q    <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pcounter_q  <= pcounter_d;
      pcounter4_q <= pcounter4_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      halted_q    <= halted_d;
      mem_full_q  <= mem_full_d;
      wr_ptr_q    <= wr_ptr_d;
      mem_q       <= mem_d;
    end
  end

  assign o_pcounter    = pcounter_q;
  assign o_pcounter4   = pcounter4_q;
  assign o_instruction = instr_q;
  assign o_valid       = valid_q;
  assign o_halted      = halted_q;
  assign o_mem_full    = mem_full_q;

endmodule

// File: tb/tb_instr_fetch_param.sv
// Directed bench for instr_fetch_param: a behavioural fetch model checked every cycle, plus literal pins.
module tb_instr_fetch_param;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_we;
  logic [31:0] i_instr_data;
  logic        i_start;
  logic        i_jump;
  logic [31:0] i_addr2jump;
  logic        i_stall;
  logic        i_halt;
  logic [31:0] o_pcounter;
  logic [31:0] o_pcounter4;
  logic [31:0] o_instruction;
  logic        o_valid;
  logic        o_halted;
  logic        o_mem_full;

  int total = 0;
  int bad   = 0;

  // Model: words loaded so far, PC, run mode (0 idle, 1 run, 2 halted) and expected outputs.
  logic [31:0] m_mem [64];
  int          m_wr;
  logic [31:0] m_pc;
  int          m_state;
  logic [31:0] e_pc, e_pc4, e_instr;
  logic        e_valid;

  instr_fetch_param dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_we         (i_we),
    .i_instr_data (i_instr_data),
    .i_start      (i_start),
    .i_jump       (i_jump),
    .i_addr2jump  (i_addr2jump),
    .i_stall      (i_stall),
    .i_halt       (i_halt),
    .o_pcounter   (o_pcounter),
    .o_pcounter4  (o_pcounter4),
    .o_instruction(o_instruction),
    .o_valid      (o_valid),
    .o_halted     (o_halted),
    .o_mem_full   (o_mem_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_mem[i] = 32'd0;
    m_wr = 0; m_pc = 32'd0; m_state = 0;
    e_pc = 32'd0; e_pc4 = 32'd0; e_instr = 32'd0; e_valid = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a >= 32'd256) return 32'd0;
    return m_mem[a[7:2]];
  endfunction

  task automatic model_edge();
    if (i_rst) begin
      model_reset();
    end else begin
      case (m_state)
        0: begin
          if (i_we && m_wr < 64) begin
            m_mem[m_wr] = i_instr_data;
            m_wr++;
          end
          if (i_start) m_state = 1;
        end
        1: begin
          if (i_halt || (e_valid && e_instr == 32'hFFFF_FFFF)) begin
            m_state = 2;
            e_valid = 1'b0;
          end else if (!i_stall) begin
            e_instr = m_read(m_pc);
            e_pc    = m_pc;
            e_pc4   = m_pc + 32'd4;
            e_valid = 1'b1;
            m_pc    = i_jump ? (i_addr2jump & 32'hFFFF_FFFC) : (m_pc + 32'd4);
          end
        end
        default: if (i_start) m_state = 1;
      endcase
    end
  endtask

  task automatic compare_all();
    chk("pcounter", o_pcounter, e_pc);
    chk("pcounter4", o_pcounter4, e_pc4);
    chk("instruction", o_instruction, e_instr);
    chk("valid", {31'd0, o_valid}, {31'd0, e_valid});
    chk("halted", {31'd0, o_halted}, {31'd0, m_state == 2});
    chk("mem_full", {31'd0, o_mem_full}, {31'd0, m_wr == 64});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    i_we = 1'b0; i_instr_data = 32'd0; i_start = 1'b0; i_jump = 1'b0;
    i_addr2jump = 32'd0; i_stall = 1'b0; i_halt = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] w);
    i_we = 1'b1; i_instr_data = w;
    step();
    i_we = 1'b0;
  endtask

  task automatic pin_out(input string nm, input logic [31:0] pc, input logic [31:0] ins, input logic v);
    chk({nm, "_pc"}, o_pcounter, pc);
    chk({nm, "_pc4"}, o_pcounter4, pc + 32'd4);
    chk({nm, "_instr"}, o_instruction, ins);
    chk({nm, "_valid"}, {31'd0, o_valid}, {31'd0, v});
  endtask

  // Reset asserted between edges must clear the outputs without waiting for a clock.
  task automatic mid_reset();
    #2;
    i_rst = 1'b1;
    #1;
    chk("async_rst_pc", o_pcounter, 32'd0);
    chk("async_rst_pc4", o_pcounter4, 32'd0);
    chk("async_rst_instr", o_instruction, 32'd0);
    chk("async_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("async_rst_halted", {31'd0, o_halted}, 32'd0);
    chk("async_rst_full", {31'd0, o_mem_full}, 32'd0);
    model_reset();
    step();
    i_rst = 1'b0;
  endtask

  logic [31:0] set_a [5];

  initial begin
    set_a[0] = 32'h8888_8888; set_a[1] = 32'hA8A8_A8A8; set_a[2] = 32'hAAAA_AAAA;
    set_a[3] = 32'h0000_FFFF; set_a[4] = 32'h0000_0000;
    idle_inputs();
    i_rst = 1'b1;
    model_reset();
    #12;
    chk("reset_pc", o_pcounter, 32'd0);
    chk("reset_instr", o_instruction, 32'd0);
    chk("reset_valid", {31'd0, o_valid}, 32'd0);
    chk("reset_halted", {31'd0, o_halted}, 32'd0);
    i_rst = 1'b0;

    // Sequential stream of four loaded words, then an unloaded address
    for (int k = 0; k < 4; k++) load_word(set_a[k]);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("start_edge_valid", {31'd0, o_valid}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      pin_out("seq", 32'(4 * k), set_a[k], 1'b1);
    end

    // Stall, stall-over-jump, delay-slot jump, halt and resume
    mid_reset();
    for (int k = 0; k < 17; k++) load_word(32'h1000_0000 + 32'(k));
    i_start = 1'b1; step(); i_start = 1'b0;
    step(); step(); step();
    pin_out("pre_stall", 32'h8, 32'h1000_0002, 1'b1);
    i_stall = 1'b1; step(); i_stall = 1'b0;
    pin_out("stall_hold", 32'h8, 32'h1000_0002, 1'b1);
    step();
    pin_out("after_stall", 32'hC, 32'h1000_0003, 1'b1);
    i_stall = 1'b1; i_jump = 1'b1; i_addr2jump = 32'h43; step();
    i_stall = 1'b0; i_jump = 1'b0;
    pin_out("stall_jump", 32'hC, 32'h1000_0003, 1'b1);
    step();
    pin_out("jump_lost", 32'h10, 32'h1000_0004, 1'b1);
    i_jump = 1'b1; i_addr2jump = 32'h43; step(); i_jump = 1'b0;
    pin_out("delay_slot", 32'h14, 32'h1000_0005, 1'b1);
    step();
    pin_out("jump_target", 32'h40, 32'h1000_0010, 1'b1);
    i_halt = 1'b1; step(); i_halt = 1'b0;
    chk("ext_halt", {31'd0, o_halted}, 32'd1);
    chk("ext_halt_valid", {31'd0, o_valid}, 32'd0);
    i_we = 1'b1; i_instr_data = 32'h0000_0055; step(); i_we = 1'b0;
    i_start = 1'b1; step(); i_start = 1'b0;
    step();
    pin_out("resume", 32'h44, 32'h0, 1'b1);
    i_jump = 1'b1; i_addr2jump = 32'h104; step(); i_jump = 1'b0;
    step();
    pin_out("out_of_range", 32'h104, 32'h0, 1'b1);

    // Bounded loading and halt opcode
    mid_reset();
    for (int k = 0; k < 66; k++) begin
      if (k == 2) load_word(32'hFFFF_FFFF);
      else if (k < 64) load_word(32'hC000_0000 + 32'(k));
      else load_word(32'hDEAD_0000 + 32'(k));
      if (k == 62) chk("not_full_63", {31'd0, o_mem_full}, 32'd0);
      if (k == 63) chk("full_64", {31'd0, o_mem_full}, 32'd1);
    end
    i_start = 1'b1; step(); i_start = 1'b0;
    step();
    pin_out("mem0_kept", 32'h0, 32'hC000_0000, 1'b1);
    step(); step();
    pin_out("halt_word", 32'h8, 32'hFFFF_FFFF, 1'b1);
    chk("halt_word_not_halted", {31'd0, o_halted}, 32'd0);
    step();
    chk("halt_opcode_halted", {31'd0, o_halted}, 32'd1);
    chk("halt_opcode_valid", {31'd0, o_valid}, 32'd0);
    step();
    i_start = 1'b1; step(); i_start = 1'b0;
    step();
    pin_out("resume_at_c", 32'hC, 32'hC000_0003, 1'b1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
